// File: rtl/cond_writeback_if.sv
// Handshake and datapath bundle between the ALU, the writeback stage
// and the register file write port.
interface cond_writeback_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Result;
    logic [63:0] ALUResult64;
    logic [3:0]  ALUFlags;
    logic [3:0]  Cond;
    logic [1:0]  FlagW;
    logic        RegW;
    logic        Long;
    logic [3:0]  RdLo;
    logic [3:0]  RdHi;
    logic        CondEx;
    logic [3:0]  Flags;
    logic        WE3;
    logic [3:0]  A3;
    logic [31:0] WD3;

    modport master (
        output in_valid, Result, ALUResult64, ALUFlags, Cond,
        output FlagW, RegW, Long, RdLo, RdHi,
        input  in_ready, CondEx, Flags, WE3, A3, WD3
    );

    modport slave (
        input  in_valid, Result, ALUResult64, ALUFlags, Cond,
        input  FlagW, RegW, Long, RdLo, RdHi,
        output in_ready, CondEx, Flags, WE3, A3, WD3
    );
endinterface

// File: rtl/cond_writeback.sv
// Conditional writeback stage: evaluates the ARM condition, updates NZCV
// and drives the single register file write port (one or two cycles).
module cond_writeback (
    input  logic               clk,
    input  logic               reset,
    cond_writeback_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WB_LO = 2'd1,
        WB_HI = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  flags_q, flags_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic [3:0]  rdlo_q, rdlo_d;
    logic [3:0]  rdhi_q, rdhi_d;
    logic        long_q, long_d;
    logic        wen_q, wen_d;

    logic        flag_n, flag_z, flag_c, flag_v;
    logic        cond_ex;
    logic        ready;
    logic        accept;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    always_comb begin
        cond_ex = 1'b0;
        unique case (bus.Cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = !flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = !flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = !flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = !flag_v;
            4'b1000: cond_ex = flag_c & !flag_z;
            4'b1001: cond_ex = !flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = !flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            4'b1111: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // A long op occupies the port for two cycles, so stall during its lo write
    assign ready  = (state_q == IDLE)
                  | ((state_q == WB_LO) & !long_q)
                  | (state_q == WB_HI);
    assign accept = bus.in_valid & ready;

    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        rdlo_d  = rdlo_q;
        rdhi_d  = rdhi_q;
        long_d  = long_q;
        wen_d   = wen_q;

        if (accept) begin
            lo_d   = bus.Long ? bus.ALUResult64[31:0] : bus.Result;
            hi_d   = bus.ALUResult64[63:32];
            rdlo_d = bus.RdLo;
            rdhi_d = bus.RdHi;
            long_d = bus.Long;
            wen_d  = bus.RegW & cond_ex;
            if (cond_ex && bus.FlagW[1]) begin
                flags_d[3:2] = bus.ALUFlags[3:2];
            end
            if (cond_ex && bus.FlagW[0]) begin
                flags_d[1:0] = bus.ALUFlags[1:0];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (accept) state_d = WB_LO;
            end
            WB_LO: begin
                if (long_q)      state_d = WB_HI;
                else if (accept) state_d = WB_LO;
                else             state_d = IDLE;
            end
            WB_HI: begin
                state_d = accept ? WB_LO : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            flags_q <= 4'b0000;
            lo_q    <= 32'd0;
            hi_q    <= 32'd0;
            rdlo_q  <= 4'd0;
            rdhi_q  <= 4'd0;
            long_q  <= 1'b0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            rdlo_q  <= rdlo_d;
            rdhi_q  <= rdhi_d;
            long_q  <= long_d;
            wen_q   <= wen_d;
        end
    end

    // Write port is decoded from registered state only
    always_comb begin
        bus.WE3 = 1'b0;
        bus.A3  = 4'd0;
        bus.WD3 = 32'd0;
        unique case (state_q)
            WB_LO: begin
                bus.WE3 = wen_q;
                bus.A3  = rdlo_q;
                bus.WD3 = lo_q;
            end
            WB_HI: begin
                bus.WE3 = wen_q;
                bus.A3  = rdhi_q;
                bus.WD3 = hi_q;
            end
            default: begin
                bus.WE3 = 1'b0;
                bus.A3  = 4'd0;
                bus.WD3 = 32'd0;
            end
        endcase
    end

    assign bus.in_ready = ready;
    assign bus.CondEx   = cond_ex;
    assign bus.Flags    = flags_q;

endmodule

// File: tb/tb_cond_writeback.sv
// Directed bench for cond_writeback: reset, flag gating, long writes,
// back-to-back ops, reset abort and the full condition table.
module tb_cond_writeback;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    cond_writeback_if bus ();

    cond_writeback dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] cond,
                         input logic [1:0] fw, input logic [3:0] af,
                         input logic rw, input logic lg,
                         input logic [3:0] rlo, input logic [3:0] rhi,
                         input logic [31:0] res, input logic [63:0] r64);
        bus.in_valid    = v;
        bus.Cond        = cond;
        bus.FlagW       = fw;
        bus.ALUFlags    = af;
        bus.RegW        = rw;
        bus.Long        = lg;
        bus.RdLo        = rlo;
        bus.RdHi        = rhi;
        bus.Result      = res;
        bus.ALUResult64 = r64;
    endtask

    function automatic logic cond_model(input logic [3:0] c,
                                        input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return ~z;
            4'h2: return cy;
            4'h3: return ~cy;
            4'h4: return n;
            4'h5: return ~n;
            4'h6: return v;
            4'h7: return ~v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(0, 4'hE, 2'b00, 4'h0, 0, 0, 4'd0, 4'd0, 32'd0, 64'd0);
        step();
        step();
        chk("rst_we3", bus.WE3, 0);
        chk("rst_a3", bus.A3, 0);
        chk("rst_wd3", bus.WD3, 0);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_flags", bus.Flags, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ADD r3 = 5
        drive(1, 4'hE, 2'b00, 4'h0, 1, 0, 4'd3, 4'd0, 32'h5, 64'd0);
        #1;
        chk("add_condex", bus.CondEx, 1);
        step();
        bus.in_valid = 1'b0;
        chk("add_we3", bus.WE3, 1);
        chk("add_a3", bus.A3, 3);
        chk("add_wd3", bus.WD3, 32'h5);
        step();
        chk("add_idle_we3", bus.WE3, 0);
        chk("add_idle_a3", bus.A3, 0);
        chk("add_idle_ready", bus.in_ready, 1);

        // SUBS sets Z,C; EQ passes then NE fails
        drive(1, 4'hE, 2'b11, 4'b0110, 1, 0, 4'd1, 4'd0, 32'h0, 64'd0);
        step();
        drive(1, 4'h0, 2'b00, 4'h0, 1, 0, 4'd2, 4'd0, 32'h11, 64'd0);
        #1;
        chk("subs_flags", bus.Flags, 4'b0110);
        chk("eq_condex", bus.CondEx, 1);
        step();
        chk("eq_we3", bus.WE3, 1);
        chk("eq_a3", bus.A3, 2);
        chk("eq_wd3", bus.WD3, 32'h11);
        drive(1, 4'h1, 2'b11, 4'hF, 1, 0, 4'd7, 4'd0, 32'h22, 64'd0);
        #1;
        chk("ne_condex", bus.CondEx, 0);
        step();
        bus.in_valid = 1'b0;
        chk("ne_we3", bus.WE3, 0);
        chk("ne_a3", bus.A3, 7);
        chk("ne_flags", bus.Flags, 4'b0110);
        step();

        // Partial update: 1001 then FlagW=10 with 0110 -> 0101
        drive(1, 4'hE, 2'b11, 4'b1001, 0, 0, 4'd0, 4'd0, 32'h0, 64'd0);
        step();
        chk("part_pre", bus.Flags, 4'b1001);
        drive(1, 4'hE, 2'b10, 4'b0110, 0, 0, 4'd0, 4'd0, 32'h0, 64'd0);
        step();
        bus.in_valid = 1'b0;
        chk("part_flags", bus.Flags, 4'b0101);
        chk("part_we3", bus.WE3, 0);
        step();

        // UMULL, with a held op presented while stalled
        drive(1, 4'hE, 2'b00, 4'h0, 1, 1, 4'd4, 4'd5, 32'h0,
              64'h00000001_FFFFFFFE);
        step();
        drive(1, 4'hE, 2'b00, 4'h0, 1, 0, 4'd9, 4'd0, 32'hDEAD, 64'd0);
        #1;
        chk("mul_lo_we3", bus.WE3, 1);
        chk("mul_lo_a3", bus.A3, 4);
        chk("mul_lo_wd3", bus.WD3, 32'hFFFFFFFE);
        chk("mul_lo_ready", bus.in_ready, 0);
        step();
        chk("mul_hi_we3", bus.WE3, 1);
        chk("mul_hi_a3", bus.A3, 5);
        chk("mul_hi_wd3", bus.WD3, 32'h1);
        chk("mul_hi_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        chk("held_a3", bus.A3, 9);
        chk("held_wd3", bus.WD3, 32'hDEAD);
        step();
        chk("mul_idle_we3", bus.WE3, 0);

        // Three back-to-back 32-bit ops
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'hE, 2'b00, 4'h0, 1, 0, 4'(10 + i), 4'd0,
                  32'h100 + 32'(i), 64'd0);
            step();
            chk("b2b_we3", bus.WE3, 1);
            chk("b2b_a3", bus.A3, 64'(10 + i));
            chk("b2b_wd3", bus.WD3, 64'h100 + 64'(i));
        end
        bus.in_valid = 1'b0;
        step();
        chk("b2b_end_we3", bus.WE3, 0);

        // Long op aborted by reset during WB_LO
        drive(1, 4'hE, 2'b11, 4'hF, 1, 1, 4'd6, 4'd8, 32'h0,
              64'hAAAA0000_5555FFFF);
        step();
        bus.in_valid = 1'b0;
        chk("abort_lo_a3", bus.A3, 6);
        chk("abort_pre_flags", bus.Flags, 4'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_we3", bus.WE3, 0);
        chk("abort_flags", bus.Flags, 0);
        chk("abort_a3", bus.A3, 0);
        step();
        chk("abort_no_hi_a3", bus.A3, 0);
        chk("abort_no_hi_we3", bus.WE3, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("abort_after_a3", bus.A3, 0);
        chk("abort_after_ready", bus.in_ready, 1);

        // Condition table sweep over all flag values
        for (int f = 0; f < 16; f++) begin
            drive(1, 4'hE, 2'b11, 4'(f), 0, 0, 4'd0, 4'd0, 32'h0, 64'd0);
            step();
            bus.in_valid = 1'b0;
            chk("sweep_flags", bus.Flags, 64'(f));
            for (int c = 0; c < 16; c++) begin
                bus.Cond = 4'(c);
                #1;
                chk($sformatf("cond_%0h_flags_%0h", c, f), bus.CondEx,
                    64'(cond_model(4'(c), 4'(f))));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
